// File: rtl/pc_redirect_ctrl.sv
// Next-PC select sequencer: steers the PC mux from EX-stage control flow, defers
// redirects that collide with a stall, and flushes wrong-path work for a fixed bubble count.
module pc_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ex_valid_i,
    input  logic [1:0]       ex_cf_type_i,
    input  logic             ex_cond_i,
    input  logic             stall_i,
    output logic [1:0]       pc_sel_o,
    output logic             branch_check_o,
    output logic             pc_write_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [1:0]        pend_q, pend_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              taken;
    logic              apply;
    logic [1:0]        apply_sel;

    assign taken = ex_valid_i & ((ex_cf_type_i == 2'b01 & ex_cond_i) | ex_cf_type_i[1]);

    // A redirect lands either straight from EX or from the held target once the stall clears.
    always_comb begin
        apply     = 1'b0;
        apply_sel = ex_cf_type_i;
        case (state_q)
            RUN:  apply = taken & ~stall_i;
            HOLD: begin
                apply     = ~stall_i;
                apply_sel = pend_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            pend_q  <= 2'b00;
            fcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: if (taken && stall_i) begin
                state_d = HOLD;
                pend_d  = ex_cf_type_i;
            end
            FLUSH: if (!stall_i) begin
                fcnt_d = fcnt_q - FC_W'(1);
                if (fcnt_q == FC_W'(1)) state_d = RUN;
            end
            default: ;
        endcase
        if (apply) begin
            cnt_d   = cnt_q + CNT_W'(1);
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
    end

    always_comb begin
        pc_sel_o       = 2'b00;
        branch_check_o = 1'b0;
        pc_write_o     = ~stall_i;
        flush_ifid_o   = 1'b0;
        flush_idex_o   = 1'b0;
        busy_o         = (state_q != RUN);
        case (state_q)
            RUN:  if (taken && stall_i) pc_write_o = 1'b0;
            HOLD: if (stall_i) begin
                pc_sel_o       = pend_q;
                branch_check_o = (pend_q == 2'b01);
            end
            FLUSH: flush_idex_o = 1'b1;
            default: ;
        endcase
        if (apply) begin
            pc_sel_o       = apply_sel;
            branch_check_o = (apply_sel == 2'b01);
            pc_write_o     = 1'b1;
            flush_ifid_o   = 1'b1;
            flush_idex_o   = 1'b1;
        end
        if (rst_i) begin
            pc_sel_o       = 2'b00;
            branch_check_o = 1'b0;
            pc_write_o     = 1'b0;
            flush_ifid_o   = 1'b0;
            flush_idex_o   = 1'b0;
            busy_o         = 1'b0;
        end
    end

    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: three configurations share one stimulus stream and are
// each compared every cycle against a transaction-level reference model.
module tb_pc_redirect_ctrl;

    localparam int FC_TAB [3] = '{2, 3, 1};
    localparam int W_TAB  [3] = '{16, 16, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  ex_cf_type;
    logic        ex_cond;
    logic        stall;

    logic [1:0]  pc_sel [3];
    logic        bchk   [3];
    logic        pw     [3];
    logic        fi     [3];
    logic        fe     [3];
    logic        busy   [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [15:0] cnt_got [3];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a held redirect, the bubbles still owed, and the redirect tally.
    bit          m_hold [3];
    int          m_sel  [3];
    int          m_left [3];
    int unsigned m_cnt  [3];

    typedef struct packed {
        logic [1:0] sel;
        logic       bc, pw, fi, fe, busy;
    } exp_t;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_cf_type_i(ex_cf_type),
        .ex_cond_i(ex_cond), .stall_i(stall), .pc_sel_o(pc_sel[0]), .branch_check_o(bchk[0]),
        .pc_write_o(pw[0]), .flush_ifid_o(fi[0]), .flush_idex_o(fe[0]), .busy_o(busy[0]),
        .redirect_cnt_o(cnt0));

    pc_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_cf_type_i(ex_cf_type),
        .ex_cond_i(ex_cond), .stall_i(stall), .pc_sel_o(pc_sel[1]), .branch_check_o(bchk[1]),
        .pc_write_o(pw[1]), .flush_ifid_o(fi[1]), .flush_idex_o(fe[1]), .busy_o(busy[1]),
        .redirect_cnt_o(cnt1));

    pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_cf_type_i(ex_cf_type),
        .ex_cond_i(ex_cond), .stall_i(stall), .pc_sel_o(pc_sel[2]), .branch_check_o(bchk[2]),
        .pc_write_o(pw[2]), .flush_ifid_o(fi[2]), .flush_idex_o(fe[2]), .busy_o(busy[2]),
        .redirect_cnt_o(cnt2));

    assign cnt_got[0] = cnt0;
    assign cnt_got[1] = cnt1;
    assign cnt_got[2] = {14'b0, cnt2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_taken();
        return ex_valid && ((ex_cf_type == 2'd1 && ex_cond) || ex_cf_type >= 2'd2);
    endfunction

    function automatic exp_t redirect_out(input int sel);
        exp_t e;
        e.sel = 2'(sel); e.bc = (sel == 1); e.pw = 1'b1; e.fi = 1'b1; e.fe = 1'b1; e.busy = 1'b0;
        return e;
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t e;
        e = '{sel: 2'd0, bc: 1'b0, pw: ~stall, fi: 1'b0, fe: 1'b0, busy: 1'b0};
        if (rst) begin
            e.pw = 1'b0;
        end else if (m_left[i] > 0) begin
            e.fe   = 1'b1;
            e.busy = 1'b1;
        end else if (m_hold[i]) begin
            if (stall) begin
                e.sel = 2'(m_sel[i]);
                e.bc  = (m_sel[i] == 1);
                e.pw  = 1'b0;
            end else begin
                e = redirect_out(m_sel[i]);
            end
            e.busy = 1'b1;
        end else if (is_taken()) begin
            if (stall) e.pw = 1'b0;
            else       e = redirect_out(int'(ex_cf_type));
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hold[i] = 1'b0; m_sel[i] = 0; m_left[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_apply(input int i, input int sel);
        m_hold[i] = 1'b0;
        m_sel[i]  = sel;
        m_cnt[i]  = (m_cnt[i] + 1) % (32'd1 << W_TAB[i]);
        m_left[i] = FC_TAB[i] - 1;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (m_left[i] > 0) begin
                if (!stall) m_left[i]--;
            end else if (m_hold[i]) begin
                if (!stall) model_apply(i, m_sel[i]);
            end else if (is_taken()) begin
                if (stall) begin
                    m_hold[i] = 1'b1;
                    m_sel[i]  = int'(ex_cf_type);
                end else begin
                    model_apply(i, int'(ex_cf_type));
                end
            end
        end
    endtask

    task automatic compare_all(input string ph);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = model_out(i);
            check($sformatf("%s[%0d] pc_sel", ph, i), 32'(pc_sel[i]), 32'(e.sel));
            check($sformatf("%s[%0d] branch_check", ph, i), 32'(bchk[i]), 32'(e.bc));
            check($sformatf("%s[%0d] pc_write", ph, i), 32'(pw[i]), 32'(e.pw));
            check($sformatf("%s[%0d] flush_ifid", ph, i), 32'(fi[i]), 32'(e.fi));
            check($sformatf("%s[%0d] flush_idex", ph, i), 32'(fe[i]), 32'(e.fe));
            check($sformatf("%s[%0d] busy", ph, i), 32'(busy[i]), 32'(e.busy));
            check($sformatf("%s[%0d] redirect_cnt", ph, i), 32'(cnt_got[i]), (rst ? 32'd0 : m_cnt[i]));
        end
    endtask

    // Drive one cycle's inputs just after an edge, check mid-cycle, advance the model at the edge.
    task automatic step(input string ph, input logic v, input logic [1:0] cf, input logic c, input logic s);
        ex_valid = v; ex_cf_type = cf; ex_cond = c; stall = s;
        #4;
        compare_all(ph);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_pulse(input string ph);
        rst = 1'b1;
        #1;
        compare_all(ph);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_cf_type = 2'd0; ex_cond = 1'b0; stall = 1'b0;
        model_reset();
        @(posedge clk); #1;
        step("reset", 1'b1, 2'd2, 1'b0, 1'b0);
        step("reset", 1'b0, 2'd0, 1'b0, 1'b1);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) step("seq", 1'b1, 2'd0, 1'b0, 1'b0);

        step("br_nt", 1'b1, 2'd1, 1'b0, 1'b0);
        step("br_t", 1'b1, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step("br_t_flush", 1'b1, 2'd0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) step("jalr_stall", 1'b1, 2'd3, 1'b0, 1'b1);
        step("jalr_go", 1'b1, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("jalr_flush", 1'b1, 2'd0, 1'b0, 1'b0);

        step("fl_stall_br", 1'b1, 2'd1, 1'b1, 1'b0);
        step("fl_stall", 1'b1, 2'd2, 1'b0, 1'b1);
        step("fl_stall", 1'b1, 2'd3, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step("fl_resume", 1'b1, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) step("fl_idle", 1'b0, 2'd0, 1'b0, 1'b0);

        step("hold_rst", 1'b1, 2'd2, 1'b0, 1'b1);
        step("hold_rst", 1'b0, 2'd0, 1'b0, 1'b1);
        reset_pulse("rst_async");
        for (int k = 0; k < 3; k++) step("post_rst", 1'b0, 2'd0, 1'b0, 1'b0);

        for (int j = 0; j < 5; j++) begin
            step("wrap_jal", 1'b1, 2'd2, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) step("wrap_gap", 1'b0, 2'd0, 1'b0, 1'b0);
        end

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) reset_pulse("rnd_rst");
            step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
